msi_bus_responder: RTL and testbench

- Memory-side responder for the MSI snooping bus.
- Cache controllers place read miss, write miss, invalidate or write-back transactions on the bus. This block accepts them one at a time and opens a snoop window in which an owning cache may abort the memory access and supply the block. Otherwise it reads its local memory after a fixed latency.
- It returns a response to the requesting thread and holds the backing store for the two-thread cache model.

---
 rtl/msi_bus_responder.sv | 167 ++++++++++++++++
 tb/tb_msi_bus_responder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msi_bus_responder.sv
// Memory-side responder for the MSI snooping bus: one transaction at a time,
// snoop window for owner aborts, fixed-latency local memory, response handshake.
module msi_bus_responder #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int SNOOP_CYC = 2,
    parameter int MEM_LAT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic              req_src,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              snoop_abort,
    input  logic [DATA_W-1:0] snoop_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_type,
    output logic              rsp_src,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_aborted,
    output logic [7:0]        abort_count
);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int CNT_MAX = (SNOOP_CYC > MEM_LAT) ? SNOOP_CYC : MEM_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] T_RD  = 2'd0;
    localparam logic [1:0] T_WR  = 2'd1;
    localparam logic [1:0] T_INV = 2'd2;
    localparam logic [1:0] T_WB  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_MEM, S_WB, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          type_q, type_d;
    logic                src_q, src_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                aborted_q, aborted_d;
    logic [7:0]          abort_cnt_q, abort_cnt_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        type_d      = type_q;
        src_d       = src_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        aborted_d   = aborted_q;
        abort_cnt_d = abort_cnt_q;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    type_d    = req_type;
                    src_d     = req_src;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    data_d    = '0;
                    aborted_d = 1'b0;
                    cnt_d     = '0;
                    case (req_type)
                        T_RD, T_WR: state_d = S_SNOOP;
                        default:    state_d = S_WB;
                    endcase
                end
            end
            S_SNOOP: begin
                if (snoop_abort) begin
                    mem_we    = 1'b1;
                    mem_wdata = snoop_data;
                    data_d    = snoop_data;
                    aborted_d = 1'b1;
                    if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
                    cnt_d     = '0;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_W'(SNOOP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_MEM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEM: begin
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    data_d    = mem_q[addr_q];
                    aborted_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                // Turnaround cycle: invalidate leaves after one edge, write-back
                // spends a second edge here and commits its data on that edge.
                if (type_q == T_INV || cnt_q != '0) begin
                    if (type_q == T_WB) begin
                        mem_we    = 1'b1;
                        mem_wdata = wdata_q;
                    end
                    data_d  = '0;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            type_q      <= '0;
            src_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            aborted_q   <= 1'b0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            type_q      <= type_d;
            src_q       <= src_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            aborted_q   <= aborted_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[addr_q] <= mem_wdata;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_type    = type_q;
    assign rsp_src     = src_q;
    assign rsp_data    = data_q;
    assign rsp_aborted = aborted_q;
    assign abort_count = abort_cnt_q;

endmodule

// File: tb/tb_msi_bus_responder.sv
// Directed bench for msi_bus_responder: latencies, data paths, aborts,
// response hold, back-to-back rejection, mid-transaction reset, saturation.
module tb_msi_bus_responder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [1:0] req_type;
    logic       req_src;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       snoop_abort;
    logic [7:0] snoop_data;
    logic       rsp_valid, rsp_ready;
    logic [1:0] rsp_type;
    logic       rsp_src;
    logic [7:0] rsp_data;
    logic       rsp_aborted;
    logic [7:0] abort_count;

    int total = 0;
    int bad   = 0;

    msi_bus_responder #(.ADDR_W(4), .DATA_W(8), .SNOOP_CYC(2), .MEM_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_src(req_src), .req_addr(req_addr), .req_wdata(req_wdata),
        .snoop_abort(snoop_abort), .snoop_data(snoop_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
        .rsp_src(rsp_src), .rsp_data(rsp_data), .rsp_aborted(rsp_aborted),
        .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    // Present a request and return #1 after its acceptance edge.
    task automatic do_req(input logic [1:0] t, input logic s, input logic [3:0] a,
                          input logic [7:0] w);
        int n = 0;
        req_type = t; req_src = s; req_addr = a; req_wdata = w;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL rsp_timeout: rsp_valid=0 after %0d edges", lat);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; req_type = 0; req_src = 0; req_addr = 0;
        req_wdata = 0; snoop_abort = 0; snoop_data = 0; rsp_ready = 1;
        #2;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 ||
            rsp_type !== 2'd0 || rsp_src !== 1'b0 || rsp_aborted !== 1'b0 ||
            abort_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%0b vld=%0b data=%h type=%0d src=%0b ab=%0b cnt=%0d required 1 0 00 0 0 0 0",
                     req_ready, rsp_valid, rsp_data, rsp_type, rsp_src, rsp_aborted, abort_count);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_read_miss();
        int lat;
        do_req(2'd0, 1'b0, 4'd3, 8'h55);
        wait_rsp(lat);
        total++;
        if (lat !== 6 || rsp_data !== 8'h00 || rsp_aborted !== 1'b0 ||
            rsp_src !== 1'b0 || rsp_type !== 2'd0) begin
            bad++;
            $display("FAIL read_miss: lat=%0d data=%h ab=%0b src=%0b type=%0d required 6 00 0 0 0",
                     lat, rsp_data, rsp_aborted, rsp_src, rsp_type);
        end
        finish_rsp();
    endtask

    task automatic test_writeback();
        int lat;
        do_req(2'd3, 1'b1, 4'd5, 8'hA7);
        wait_rsp(lat);
        total++;
        if (lat !== 2 || rsp_data !== 8'h00 || rsp_type !== 2'd3 || rsp_src !== 1'b1) begin
            bad++;
            $display("FAIL writeback_rsp: lat=%0d data=%h type=%0d src=%0b required 2 00 3 1",
                     lat, rsp_data, rsp_type, rsp_src);
        end
        finish_rsp();
        do_req(2'd0, 1'b0, 4'd5, 8'h00);
        wait_rsp(lat);
        total++;
        if (lat !== 6 || rsp_data !== 8'hA7 || rsp_aborted !== 1'b0) begin
            bad++;
            $display("FAIL writeback_readback: lat=%0d data=%h ab=%0b required 6 a7 0",
                     lat, rsp_data, rsp_aborted);
        end
        finish_rsp();
    endtask

    task automatic test_abort();
        int lat;
        // Held from before E0, so the acceptance edge also sees it and must ignore it.
        snoop_abort = 1'b1; snoop_data = 8'h3C;
        do_req(2'd0, 1'b1, 4'd5, 8'h00);
        wait_rsp(lat);
        total++;
        if (lat !== 1 || rsp_data !== 8'h3C || rsp_aborted !== 1'b1 ||
            abort_count !== 8'd1 || rsp_src !== 1'b1) begin
            bad++;
            $display("FAIL abort_rsp: lat=%0d data=%h ab=%0b cnt=%0d src=%0b required 1 3c 1 1 1",
                     lat, rsp_data, rsp_aborted, abort_count, rsp_src);
        end
        finish_rsp();
        snoop_abort = 1'b0; snoop_data = 8'h00;
        do_req(2'd0, 1'b0, 4'd5, 8'h00);
        wait_rsp(lat);
        total++;
        if (lat !== 6 || rsp_data !== 8'h3C || rsp_aborted !== 1'b0) begin
            bad++;
            $display("FAIL abort_readback: lat=%0d data=%h ab=%0b required 6 3c 0",
                     lat, rsp_data, rsp_aborted);
        end
        finish_rsp();
    endtask

    task automatic test_write_miss();
        int lat;
        do_req(2'd1, 1'b1, 4'd5, 8'hFF);
        wait_rsp(lat);
        total++;
        if (lat !== 6 || rsp_data !== 8'h3C || rsp_type !== 2'd1 || rsp_aborted !== 1'b0) begin
            bad++;
            $display("FAIL write_miss: lat=%0d data=%h type=%0d ab=%0b required 6 3c 1 0",
                     lat, rsp_data, rsp_type, rsp_aborted);
        end
        finish_rsp();
        do_req(2'd0, 1'b0, 4'd5, 8'h00);
        wait_rsp(lat);
        total++;
        if (rsp_data !== 8'h3C) begin
            bad++;
            $display("FAIL write_miss_nowrite: data=%h required 3c", rsp_data);
        end
        finish_rsp();
    endtask

    task automatic test_invalidate_hold();
        int lat;
        logic [7:0] d0;
        logic [1:0] t0;
        logic s0, a0, ok;
        rsp_ready = 1'b0;
        do_req(2'd2, 1'b1, 4'd2, 8'h99);
        wait_rsp(lat);
        total++;
        if (lat !== 1 || rsp_type !== 2'd2 || rsp_data !== 8'h00 || rsp_src !== 1'b1) begin
            bad++;
            $display("FAIL invalidate_rsp: lat=%0d type=%0d data=%h src=%0b required 1 2 00 1",
                     lat, rsp_type, rsp_data, rsp_src);
        end
        d0 = rsp_data; t0 = rsp_type; s0 = rsp_src; a0 = rsp_aborted; ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== d0 ||
                rsp_type !== t0 || rsp_src !== s0 || rsp_aborted !== a0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rsp_hold: vld=%0b rdy=%0b data=%h type=%0d required 1 0 00 2",
                     rsp_valid, req_ready, rsp_data, rsp_type);
        end
        finish_rsp();
        do_req(2'd0, 1'b0, 4'd2, 8'h00);
        wait_rsp(lat);
        total++;
        if (rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL invalidate_mem: data=%h required 00", rsp_data);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        int lat;
        do_req(2'd2, 1'b0, 4'd1, 8'h00);
        wait_rsp(lat);
        req_valid = 1'b1; req_type = 2'd2; req_src = 1'b1; req_addr = 4'd1;
        @(posedge clk); #1;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_not_taken: vld=%0b rdy=%0b required 0 1", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: rdy=%0b vld=%0b required 0 0", req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_src !== 1'b1) begin
            bad++;
            $display("FAIL b2b_rsp: vld=%0b src=%0b required 1 1", rsp_valid, rsp_src);
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen = 1'b0;
        do_req(2'd0, 1'b1, 4'd5, 8'h00);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || abort_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid: rdy=%0b vld=%0b cnt=%0d required 1 0 0",
                     req_ready, rsp_valid, abort_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_rsp: rsp seen=%0b required 0", seen);
        end
        do_req(2'd0, 1'b0, 4'd5, 8'h00);
        wait_rsp(lat);
        total++;
        if (lat !== 6 || rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_mem: lat=%0d data=%h required 6 00", lat, rsp_data);
        end
        finish_rsp();
    endtask

    task automatic test_saturate();
        int lat;
        logic ok = 1'b1;
        snoop_abort = 1'b1;
        for (int i = 0; i < 260; i++) begin
            snoop_data = 8'(i);
            do_req(2'd0, 1'b0, 4'd5, 8'h00);
            wait_rsp(lat);
            if (lat !== 1 || rsp_aborted !== 1'b1) ok = 1'b0;
            finish_rsp();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL saturate_lat: some aborted access lat/aborted wrong, last lat=%0d required 1", lat);
        end
        total++;
        if (abort_count !== 8'd255) begin
            bad++;
            $display("FAIL saturate_cnt: abort_count=%0d required 255", abort_count);
        end
        snoop_data = 8'h99;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (abort_count !== 8'd255 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_abort: cnt=%0d rdy=%0b vld=%0b required 255 1 0",
                     abort_count, req_ready, rsp_valid);
        end
        snoop_abort = 1'b0;
        do_req(2'd0, 1'b0, 4'd5, 8'h00);
        wait_rsp(lat);
        total++;
        if (rsp_data !== 8'h03 || rsp_aborted !== 1'b0) begin
            bad++;
            $display("FAIL idle_abort_mem: data=%h ab=%0b required 03 0", rsp_data, rsp_aborted);
        end
        finish_rsp();
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_writeback();
        test_abort();
        test_write_miss();
        test_invalidate_hold();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
